calc_bcd_converter: RTL and testbench
=====================================

CALC_BCD_CONVERTER -- requirements
Module: calc_bcd_converter

Interface
REQ-001 SHALL have parameter BIN_W, default 16, the binary input width (matches the calculator's 16-bit result).
REQ-002 SHALL have parameter DIGITS, default 5, the BCD digit count; it SHALL satisfy 10^DIGITS > 2^BIN_W.
REQ-003 Port clk  input  1  is the single clock; all state updates on its rising edge.
REQ-004 Port rst  input  1  is the asynchronous, active-high reset.
REQ-005 Port in_valid  input  1  indicates that bin carries a calculator result to convert.
REQ-006 Port bin  input  BIN_W  is the unsigned binary result (calculator out[15:0]).
REQ-007 Port in_ready  output  1  indicates the block accepts a new input this cycle.
REQ-008 Port out_valid  output  1  indicates bcd and digit_en hold a finished conversion.
REQ-009 Port out_ready  input  1  indicates the consumer (display stage) takes the result.
REQ-010 Port bcd  output  4*DIGITS  holds packed BCD, with digit 0 (units) in bits [3:0].
REQ-011 Port digit_en  output  DIGITS  is the leading-zero-blank mask; bit i is set when digit i is significant.

Function
REQ-012 SHALL implement FSM states IDLE, SHIFT and DONE.
REQ-013 IDLE: in_ready=1; on in_valid&&in_ready SHALL latch bin, clear the BCD accumulator and count, and go to SHIFT.
REQ-014 SHIFT: each cycle SHALL add 3 to every accumulator digit >=5, then shift {accumulator, binary} left one bit (double-dabble).
REQ-015 SHALL perform exactly BIN_W SHIFT cycles, then enter DONE on the edge of the last shift.
REQ-016 Latency SHALL be BIN_W cycles: out_valid rises on the BIN_W-th rising edge after the accepting edge.
REQ-017 DONE: out_valid=1, and bcd and digit_en SHALL remain stable until out_valid&&out_ready.
REQ-018 On out_valid&&out_ready SHALL return to IDLE on that edge; out_valid SHALL deassert the next cycle.
REQ-019 in_ready SHALL be 0 in SHIFT and DONE; in_valid in those states SHALL be ignored, and the input is not consumed.
REQ-020 Back-to-back conversions SHALL incur exactly one IDLE bubble cycle between a DONE handoff and the next accept.
REQ-021 digit_en[0] SHALL always be 1; digit_en[i] for i>0 SHALL be 1 iff any digit j>=i is nonzero.
REQ-022 bcd and digit_en SHALL be 0 outside DONE.
REQ-023 Values of bin above 10^DIGITS-1 cannot occur (REQ-002); no overflow output exists.
REQ-024 Each BCD digit SHALL stay in the range 0..9 after every SHIFT cycle.

Reset
REQ-025 While rst is asserted, the block SHALL be in IDLE with in_ready=1, out_valid=0, bcd=0, digit_en=0, and count=0.
REQ-026 Reset asserted mid-SHIFT or in DONE SHALL abort immediately; the partial result SHALL be discarded and never presented.
REQ-027 After rst deasserts, the first accept SHALL be possible on the first rising edge.

Structure
REQ-028 Shared package calc_pkg SHALL hold the FSM state enum (IDLE, SHIFT, DONE) and the BIN_W/DIGITS default constants.
REQ-029 The conditional add-3 per digit SHALL be a sub-module calc_bcd_digit (4-bit in, 4-bit out), instantiated DIGITS times.
REQ-030 The count register SHALL be clog2(BIN_W+1) bits wide.

Verification
REQ-031 bin=0 -> bcd=0x00000, digit_en=00001, out_valid exactly 16 cycles after accept.
REQ-032 bin=65535 -> bcd=0x65535, digit_en=11111.
REQ-033 bin=64 (calculator 16*4) -> bcd=0x00064, digit_en=00011; bin=2 (1+1) -> bcd=0x00002, digit_en=00001.
REQ-034 Backpressure: out_ready held low 5 cycles after out_valid -> bcd held stable, in_ready=0, and a pending in_valid is not accepted until one cycle after the handoff.
REQ-035 Reset asserted on the 8th SHIFT cycle of bin=12345 -> out_valid stays 0, in_ready=1 after reset; a new bin=192 then yields bcd=0x00192, digit_en=00111.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared constants and FSM state encoding for the calculator BCD path.
package calc_pkg;

    localparam int BIN_W_DEFAULT  = 16;
    localparam int DIGITS_DEFAULT = 5;

    // FSM state encoding (kept as plain constants for legacy compatibility)
    typedef logic [1:0] state_t;
    localparam state_t IDLE  = 2'd0;
    localparam state_t SHIFT = 2'd1;
    localparam state_t DONE  = 2'd2;

endpackage

// File: rtl/calc_bcd_digit.sv
// Double-dabble digit correction: add 3 when the digit is 5 or more so that
// the following left shift carries correctly into the next decimal digit.
module calc_bcd_digit (
    input  logic [3:0] din,
    output logic [3:0] dout
);

    // Conditional add-3
    always_comb begin
        dout = din;
        if (din >= 4'd5) begin
            dout = din + 4'd3;
        end
    end

endmodule

// File: rtl/calc_bcd_converter.sv
// Serial binary-to-BCD converter (double-dabble), one bit per cycle, with
// valid/ready handshakes on both sides and a leading-zero-blank mask.
module calc_bcd_converter
    import calc_pkg::*;
#(
    parameter int BIN_W  = BIN_W_DEFAULT,
    parameter int DIGITS = DIGITS_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    input  logic [BIN_W-1:0]    bin,
    output logic                in_ready,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [4*DIGITS-1:0] bcd,
    output logic [DIGITS-1:0]   digit_en
);

    localparam int ACC_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BIN_W-1:0]   sh_q, sh_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [ACC_W-1:0]   acc_adj;

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        calc_bcd_digit u_digit (
            .din  (acc_q[4*g +: 4]),
            .dout (acc_adj[4*g +: 4])
        );
    end

    // Next-state logic: accept, shift BIN_W times, hold result until taken
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        acc_d   = acc_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sh_d    = bin;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                acc_d = {acc_adj[ACC_W-2:0], sh_q[BIN_W-1]};
                sh_d  = {sh_q[BIN_W-2:0], 1'b0};
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    acc_d   = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers; reset discards any conversion in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sh_q    <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            acc_q   <= acc_d;
        end
    end

    // Outputs: result and blank mask are only exposed in DONE
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        bcd       = '0;
        digit_en  = '0;
        if (state_q == DONE) begin
            bcd         = acc_q;
            digit_en[0] = 1'b1;
            for (int i = 1; i < DIGITS; i++) begin
                digit_en[i] = |(acc_q >> (4 * i));
            end
        end
    end

endmodule

// File: tb/tb_calc_bcd_converter.sv
// Self-checking bench for calc_bcd_converter: directed vector table, random
// values against an arithmetic decimal model, backpressure and reset abort.
module tb_calc_bcd_converter;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [15:0] bin;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready;
    logic [19:0] bcd;
    logic [4:0]  digit_en;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [15:0] bin;
        logic [19:0] bcd;
        logic [4:0]  en;
    } vec_t;

    vec_t vecs[10];

    calc_bcd_converter dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .bin       (bin),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .bcd       (bcd),
        .digit_en  (digit_en)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Decimal reference: digits by division, mask by magnitude
    function automatic logic [19:0] ref_bcd(input int unsigned v);
        logic [19:0] r = '0;
        int unsigned x = v;
        for (int i = 0; i < 5; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic logic [4:0] ref_en(input int unsigned v);
        logic [4:0] e = 5'b00001;
        int unsigned p = 10;
        for (int i = 1; i < 5; i++) begin
            e[i] = (v >= p);
            p = p * 10;
        end
        return e;
    endfunction

    // Wait for out_valid; lat is the number of edges after the accept edge
    task automatic wait_done(output int lat);
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic handoff(input string nm);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({nm, " out_valid after handoff"}, 32'(out_valid), 32'd0);
        chk({nm, " in_ready after handoff"}, 32'(in_ready), 32'd1);
        chk({nm, " bcd after handoff"}, 32'(bcd), 32'd0);
    endtask

    // Full conversion starting in IDLE, #1 after a clock edge
    task automatic convert(input logic [15:0] b, input logic [19:0] eb, input logic [4:0] ee,
                           input string nm);
        int lat;
        chk({nm, " in_ready idle"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        bin      = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        bin      = 16'($urandom);
        chk({nm, " in_ready shift"}, 32'(in_ready), 32'd0);
        chk({nm, " bcd shift"}, 32'(bcd), 32'd0);
        wait_done(lat);
        chk({nm, " latency"}, 32'(lat), 32'd16);
        chk({nm, " bcd"}, 32'(bcd), 32'(eb));
        chk({nm, " digit_en"}, 32'(digit_en), 32'(ee));
        handoff(nm);
    endtask

    initial begin
        int lat;
        int unsigned v;

        vecs[0] = '{16'd0,     20'h00000, 5'b00001};
        vecs[1] = '{16'd65535, 20'h65535, 5'b11111};
        vecs[2] = '{16'd64,    20'h00064, 5'b00011};
        vecs[3] = '{16'd2,     20'h00002, 5'b00001};
        vecs[4] = '{16'd9,     20'h00009, 5'b00001};
        vecs[5] = '{16'd10,    20'h00010, 5'b00011};
        vecs[6] = '{16'd99,    20'h00099, 5'b00011};
        vecs[7] = '{16'd1000,  20'h01000, 5'b01111};
        vecs[8] = '{16'd10000, 20'h10000, 5'b11111};
        vecs[9] = '{16'd40999, 20'h40999, 5'b11111};

        rst       = 1'b1;
        in_valid  = 1'b0;
        bin       = '0;
        out_ready = 1'b0;
        #1;
        chk("reset in_ready", 32'(in_ready), 32'd1);
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset bcd", 32'(bcd), 32'd0);
        chk("reset digit_en", 32'(digit_en), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            convert(vecs[i].bin, vecs[i].bcd, vecs[i].en, $sformatf("vec%0d", i));
        end

        for (int i = 0; i < 24; i++) begin
            v = $urandom_range(0, 65535);
            convert(16'(v), ref_bcd(v), ref_en(v), $sformatf("rand%0d(%0d)", i, v));
        end

        // Backpressure: in_valid held high throughout must not be taken early
        in_valid = 1'b1;
        bin      = 16'd500;
        @(posedge clk);
        #1;
        bin = 16'd777;
        wait_done(lat);
        chk("bp latency", 32'(lat), 32'd16);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            chk($sformatf("bp hold%0d out_valid", c), 32'(out_valid), 32'd1);
            chk($sformatf("bp hold%0d bcd", c), 32'(bcd), 32'h00500);
            chk($sformatf("bp hold%0d digit_en", c), 32'(digit_en), 32'b00111);
            chk($sformatf("bp hold%0d in_ready", c), 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("bp bubble out_valid", 32'(out_valid), 32'd0);
        chk("bp bubble in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("bp second accepted", 32'(in_ready), 32'd0);
        wait_done(lat);
        chk("bp second latency", 32'(lat), 32'd16);
        chk("bp second bcd", 32'(bcd), 32'h00777);
        chk("bp second digit_en", 32'(digit_en), 32'b00111);
        handoff("bp second");

        // Reset during the 8th shift cycle of 12345
        in_valid = 1'b1;
        bin      = 16'd12345;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("abort out_valid", 32'(out_valid), 32'd0);
        chk("abort in_ready", 32'(in_ready), 32'd1);
        chk("abort bcd", 32'(bcd), 32'd0);
        @(posedge clk);
        #1;
        chk("abort held out_valid", 32'(out_valid), 32'd0);
        chk("abort held digit_en", 32'(digit_en), 32'd0);
        rst = 1'b0;
        convert(16'd192, 20'h00192, 5'b00111, "after abort");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, expected finish before 200000");
        $fatal(1);
    end

endmodule
